// File: rtl/mem_read_arbiter_pkg.sv
// Shared definitions for the unified-memory read arbiter.
//   BUS_WIDTH    : default width of every address/data bus
//   arb_state_e  : arbiter FSM encoding (IDLE=0, ADDR=1, DATA=2)
//   arb_owner_e  : which master owns the in-flight read (I or D)
package mem_read_arbiter_pkg;

  localparam int BUS_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_I = 1'b0,
    ARB_OWNER_D = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_read_arbiter_rr_arbiter2.sv
// Two-input round-robin grant, purely combinational.
// Ports:
//   req_i   [1:0] : request vector (bit 0 = master 0, bit 1 = master 1)
//   last_i        : index of the master granted most recently
//   grant_o [1:0] : one-hot grant (all zero when nothing requests)
// On a tie the master that was not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Merges the instruction-read (i_*) and data-read (d_*) channels onto one
// memory read port (m_*). One read in flight at a time, round-robin between
// the two masters, returned data routed to the master that issued the read.
// Ports:
//   clk, rst                       : clock (rising edge), async active-high reset
//   i_addr_valid/ready, i_addr     : instruction address request channel
//   i_data_valid/ready, i_data     : instruction read data channel
//   d_addr_valid/ready, d_addr     : data address request channel
//   d_data_valid/ready, d_data     : data read data channel
//   m_addr_valid/ready, m_addr     : memory address channel (m_addr registered)
//   m_data_valid/ready, m_data     : memory read data channel
// Optional build macro MEM_READ_ARB_PERF_EN adds the free-running, wrapping
// counters i_grant_cnt, d_grant_cnt and conflict_cnt. Arbitration behaviour
// is identical with or without it.
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_WIDTH,
  parameter int DATA_WIDTH = BUS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_addr_valid,
  output logic                  i_addr_ready,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_data_valid,
  input  logic                  i_data_ready,
  output logic [DATA_WIDTH-1:0] i_data,
  input  logic                  d_addr_valid,
  output logic                  d_addr_ready,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_data_valid,
  input  logic                  d_data_ready,
  output logic [DATA_WIDTH-1:0] d_data,
  output logic                  m_addr_valid,
  input  logic                  m_addr_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  input  logic                  m_data_valid,
  output logic                  m_data_ready,
  input  logic [DATA_WIDTH-1:0] m_data
`ifdef MEM_READ_ARB_PERF_EN
  ,
  output logic [31:0]           i_grant_cnt,
  output logic [31:0]           d_grant_cnt,
  output logic [31:0]           conflict_cnt
`endif
);

  arb_state_e            state_q, state_d;
  arb_owner_e            owner_q, owner_d;
  arb_owner_e            last_q, last_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [1:0]            grant;

  rr_arbiter2 u_rr (
    .req_i   ({d_addr_valid, i_addr_valid}),
    .last_i  (last_q == ARB_OWNER_D),
    .grant_o (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= ARB_OWNER_I;
      last_q   <= ARB_OWNER_D;
      m_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      m_addr_q <= m_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    m_addr_d     = m_addr_q;
    i_addr_ready = 1'b0;
    d_addr_ready = 1'b0;
    m_addr_valid = 1'b0;
    m_data_ready = 1'b0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        // Readies are held low while rst is asserted so nothing is accepted
        // into a register that is being cleared.
        i_addr_ready = grant[0] & ~rst;
        d_addr_ready = grant[1] & ~rst;
        if (grant[0]) begin
          m_addr_d = i_addr;
          owner_d  = ARB_OWNER_I;
          last_d   = ARB_OWNER_I;
          state_d  = ARB_ADDR;
        end else if (grant[1]) begin
          m_addr_d = d_addr;
          owner_d  = ARB_OWNER_D;
          last_d   = ARB_OWNER_D;
          state_d  = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        m_addr_valid = 1'b1;
        if (m_addr_ready) begin
          state_d = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (owner_q == ARB_OWNER_I) begin
          m_data_ready = i_data_ready;
          i_data_valid = m_data_valid;
        end else begin
          m_data_ready = d_data_ready;
          d_data_valid = m_data_valid;
        end
        if (m_data_valid && m_data_ready) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign m_addr = m_addr_q;
  // Data buses are shared; only the owner's valid qualifies them.
  assign i_data = m_data;
  assign d_data = m_data;

`ifdef MEM_READ_ARB_PERF_EN
  logic [31:0] i_grant_cnt_q;
  logic [31:0] d_grant_cnt_q;
  logic [31:0] conflict_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_grant_cnt_q  <= '0;
      d_grant_cnt_q  <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (i_addr_valid && i_addr_ready) begin
        i_grant_cnt_q <= i_grant_cnt_q + 32'd1;
      end
      if (d_addr_valid && d_addr_ready) begin
        d_grant_cnt_q <= d_grant_cnt_q + 32'd1;
      end
      if ((state_q == ARB_IDLE) && i_addr_valid && d_addr_valid) begin
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
    end
  end

  assign i_grant_cnt  = i_grant_cnt_q;
  assign d_grant_cnt  = d_grant_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
